// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the signals shared between the producers, the consumer-side snoop
// and the FIFO write-port arbiter.
//   master : producer/consumer side. Drives the requests and the snooped read
//            signals, and observes the grants and the FIFO write port.
//   slave  : the arbiter itself.
// Signals:
//   req           N        per-requester write request (level)
//   req_data      N*WIDTH  requester i's word in [i*WIDTH +: WIDTH]
//   req_mask      N        1 = requester enabled
//   gnt           N        one-hot grant pulse
//   fifo_wr_en    1        FIFO write enable
//   fifo_wr_data  WIDTH    FIFO write data
//   fifo_rd_en    1        consumer read enable (snooped)
//   fifo_empty    1        FIFO empty flag (snooped)
//   occupancy     CNT_W    committed entry count
//   underflow_err 1        sticky read-while-empty error
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_mask;
    logic [N-1:0]       gnt;
    logic               fifo_wr_en;
    logic [WIDTH-1:0]   fifo_wr_data;
    logic               fifo_rd_en;
    logic               fifo_empty;
    logic [CNT_W-1:0]   occupancy;
    logic               underflow_err;

    modport master (
        output req, req_data, req_mask, fifo_rd_en, fifo_empty,
        input  gnt, fifo_wr_en, fifo_wr_data, occupancy, underflow_err
    );

    modport slave (
        input  req, req_data, req_mask, fifo_rd_en, fifo_empty,
        output gnt, fifo_wr_en, fifo_wr_data, occupancy, underflow_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one synchronous FIFO write port among N producers. Round-robin
// arbitration with bursts of up to MAX_BURST consecutive grants per owner.
// An exact occupancy count is kept from issued writes and accepted reads,
// because the FIFO's registered flags lag by a cycle and cannot prevent
// overflow on their own.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    fifo_wr_arbiter_if.slave (requests, grants, FIFO write port,
//          read snoop, occupancy, underflow error)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 5,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int PTR_W   = (N > 1) ? $clog2(N) : 1;
    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    // Registered state
    logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]   owner_q,     owner_d;
    logic               owner_vld_q, owner_vld_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [N-1:0]       gnt_q,       gnt_d;
    logic               wr_en_q,     wr_en_d;
    logic [WIDTH-1:0]   wr_data_q,   wr_data_d;
    logic [CNT_W-1:0]   occ_q,       occ_d;
    logic               uf_q,        uf_d;

    // Per-cycle qualifiers
    logic [N-1:0]     eligible;
    logic             rd_acc;
    logic             space;
    logic             win;
    logic             burst_go;
    logic [PTR_W-1:0] rot_winner;
    logic             rot_found;
    logic [PTR_W-1:0] winner;

    assign eligible = bus.req & bus.req_mask;
    assign rd_acc   = bus.fifo_rd_en & ~bus.fifo_empty;
    // Uses the committed count only: a read accepted this cycle frees space
    // from the next cycle on, never the same cycle.
    assign space    = (occ_q < CNT_W'(DEPTH));
    assign win      = space && (eligible != '0);
    assign burst_go = owner_vld_q && eligible[owner_q] &&
                      (int'(burst_cnt_q) < MAX_BURST - 1);

    // First eligible requester scanning upward from rr_ptr, wrapping at N.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rot_found  = 1'b0;
        rot_winner = '0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!rot_found && eligible[idx]) begin
                rot_found  = 1'b1;
                rot_winner = PTR_W'(idx);
            end
        end
    end

    // Next-state: arbitration, grant stage and occupancy accounting.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        burst_cnt_d = burst_cnt_q;
        gnt_d       = '0;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        winner      = '0;
        occ_d       = occ_q;
        uf_d        = uf_q;

        if (win) begin
            if (burst_go) begin
                winner      = owner_q;
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                winner      = rot_winner;
                owner_d     = rot_winner;
                owner_vld_d = 1'b1;
                burst_cnt_d = '0;
                rr_ptr_d    = (rot_winner == PTR_W'(N - 1)) ? '0
                                                            : rot_winner + 1'b1;
            end
            gnt_d     = N'(1) << winner;
            wr_en_d   = 1'b1;
            wr_data_d = bus.req_data[winner*WIDTH +: WIDTH];
        end else if (owner_vld_q && !eligible[owner_q]) begin
            // Owner went away while stalled or idle: forget it so the next
            // win goes through rotation.
            owner_vld_d = 1'b0;
        end

        // A read with nothing committed is a consumer error; the count is
        // clamped at zero and the error is held until reset.
        if (rd_acc && (occ_q == '0)) begin
            uf_d = 1'b1;
        end
        if (win && !rd_acc) begin
            occ_d = occ_q + 1'b1;
        end else if (!win && rd_acc && (occ_q != '0)) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (!reset) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            burst_cnt_q <= '0;
            gnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            occ_q       <= '0;
            uf_q        <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_q       <= gnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            occ_q       <= occ_d;
            uf_q        <= uf_d;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.fifo_wr_en    = wr_en_q;
    assign bus.fifo_wr_data  = wr_data_q;
    assign bus.occupancy     = occ_q;
    assign bus.underflow_err = uf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed-vector bench for fifo_wr_arbiter (N=4, WIDTH=8, DEPTH=16,
// MAX_BURST=4). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, i.e. they show what the last edge registered.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
    localparam int N         = 4;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = 5;
    localparam int MAX_BURST = 4;

    logic clk;
    logic reset;

    int n_vectors;
    int n_miscompares;

    fifo_wr_arbiter_if #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fifo_wr_arbiter #(
        .N(N), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs then reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        bus.req_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        reset         = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.req_mask  = '1;
        bus.fifo_rd_en = 1'b0;
        bus.fifo_empty = 1'b1;

        // ---- reset state
        step();
        step();
        check("rst_gnt",   32'(bus.gnt), 32'h0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check("rst_data",  32'(bus.fifo_wr_data), 32'h0);
        check("rst_occ",   32'(bus.occupancy), 32'h0);
        check("rst_uf",    32'(bus.underflow_err), 32'h0);
        reset = 1'b1;

        // ---- single requester, one word
        bus.req = 4'b0001;
        set_data(0, 8'hA5);
        step();
        bus.req = 4'b0000;
        check("single_gnt",   32'(bus.gnt), 32'h1);
        check("single_wr_en", 32'(bus.fifo_wr_en), 32'h1);
        check("single_data",  32'(bus.fifo_wr_data), 32'hA5);
        check("single_occ",   32'(bus.occupancy), 32'd1);
        step();
        check("idle_gnt",   32'(bus.gnt), 32'h0);
        check("idle_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check("idle_data_hold", 32'(bus.fifo_wr_data), 32'hA5);
        check("idle_occ",   32'(bus.occupancy), 32'd1);

        // ---- round robin with bursts of 4 until full
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 8'(8'hC0 + i));
        bus.req = 4'b1111;
        for (int k = 0; k < DEPTH; k++) begin
            step();
            check($sformatf("rr_gnt_%0d", k),  32'(bus.gnt), 32'(1) << (k / 4));
            check($sformatf("rr_data_%0d", k), 32'(bus.fifo_wr_data), 32'(8'hC0 + k / 4));
            check($sformatf("rr_occ_%0d", k),  32'(bus.occupancy), 32'(k + 1));
        end
        step();
        check("full_gnt",   32'(bus.gnt), 32'h0);
        check("full_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check("full_occ",   32'(bus.occupancy), 32'd16);

        // ---- full-stall release: one read frees exactly one grant
        bus.req = 4'b0010;
        step();
        check("stall_gnt", 32'(bus.gnt), 32'h0);
        check("stall_occ", 32'(bus.occupancy), 32'd16);
        bus.fifo_rd_en = 1'b1;
        bus.fifo_empty = 1'b0;
        step();
        bus.fifo_rd_en = 1'b0;
        check("release_rd_gnt", 32'(bus.gnt), 32'h0);
        check("release_rd_occ", 32'(bus.occupancy), 32'd15);
        step();
        check("release_gnt",  32'(bus.gnt), 32'h2);
        check("release_data", 32'(bus.fifo_wr_data), 32'hC1);
        check("release_occ",  32'(bus.occupancy), 32'd16);
        step();
        check("refull_gnt", 32'(bus.gnt), 32'h0);
        check("refull_occ", 32'(bus.occupancy), 32'd16);
        bus.req = 4'b0000;

        // ---- simultaneous write and read hold occupancy
        do_reset();
        bus.fifo_empty = 1'b1;
        bus.req = 4'b0001;
        for (int k = 0; k < 5; k++) step();
        check("fill5_occ", 32'(bus.occupancy), 32'd5);
        bus.fifo_rd_en = 1'b1;
        bus.fifo_empty = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("wr_rd_gnt_%0d", k), 32'(bus.gnt), 32'h1);
            check($sformatf("wr_rd_occ_%0d", k), 32'(bus.occupancy), 32'd5);
        end
        bus.req = 4'b0000;
        bus.fifo_rd_en = 1'b0;
        step();
        check("wr_rd_end_occ", 32'(bus.occupancy), 32'd5);
        check("wr_rd_end_gnt", 32'(bus.gnt), 32'h0);

        // ---- masking the owner mid-burst
        do_reset();
        bus.fifo_empty = 1'b1;
        bus.req = 4'b0011;
        bus.req_mask = 4'b1111;
        step();
        check("mask_gnt_a", 32'(bus.gnt), 32'h1);
        step();
        check("mask_gnt_b", 32'(bus.gnt), 32'h1);
        bus.req_mask = 4'b1110;
        step();
        check("mask_gnt_c", 32'(bus.gnt), 32'h2);
        check("mask_occ",   32'(bus.occupancy), 32'd3);
        bus.req = 4'b0000;
        bus.req_mask = 4'b1111;

        // ---- underflow: read accepted with nothing committed
        do_reset();
        bus.fifo_rd_en = 1'b1;
        bus.fifo_empty = 1'b0;
        step();
        bus.fifo_rd_en = 1'b0;
        bus.fifo_empty = 1'b1;
        check("uf_set", 32'(bus.underflow_err), 32'h1);
        check("uf_occ", 32'(bus.occupancy), 32'd0);
        step();
        check("uf_sticky", 32'(bus.underflow_err), 32'h1);
        do_reset();
        check("uf_cleared", 32'(bus.underflow_err), 32'h0);

        // ---- reset mid-burst
        bus.req = 4'b1111;
        step();
        check("mb_gnt_a", 32'(bus.gnt), 32'h1);
        step();
        check("mb_gnt_b", 32'(bus.gnt), 32'h1);
        bus.req = 4'b1110;
        reset = 1'b0;
        step();
        check("mb_rst_gnt",   32'(bus.gnt), 32'h0);
        check("mb_rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
        check("mb_rst_occ",   32'(bus.occupancy), 32'd0);
        reset = 1'b1;
        step();
        check("mb_after_gnt",  32'(bus.gnt), 32'h2);
        check("mb_after_data", 32'(bus.fifo_wr_data), 32'hC1);
        check("mb_after_occ",  32'(bus.occupancy), 32'd1);
        bus.req = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one sync FIFO write port (DEPTH=16, WIDTH=8) between N producers using round-robin arbitration with bounded bursts.
- Keeps its own exact occupancy count from issued writes and accepted reads, because the FIFO's registered full/empty flags lag by one cycle and cannot by themselves prevent overflow.
- Sits between the producer blocks and the FIFO's wr_en/input_data. It also snoops the consumer's rd_en and the FIFO's empty flag.

Parameters:
- N, 4, number of requesters.
- WIDTH, 8, data width; must match the FIFO.
- DEPTH, 16, FIFO depth in entries.
- CNT_W, 5, occupancy counter width = log2(DEPTH)+1.
- MAX_BURST, 4, maximum consecutive grants to one requester before rotation (≥1).

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  N  per-requester write request; level, held until granted.
- req_data  in  N*WIDTH  requester i's data in bits [i*WIDTH +: WIDTH]; stable while req[i] is high.
- req_mask  in  N  1 = requester enabled; a masked requester is never granted.
- gnt  out  N  one-hot grant pulse, registered.
- fifo_wr_en  out  1  drives the FIFO wr_en, registered.
- fifo_wr_data  out  WIDTH  drives the FIFO input_data, registered.
- fifo_rd_en  in  1  consumer read enable, snooped.
- fifo_empty  in  1  FIFO empty flag, snooped.
- occupancy  out  CNT_W  committed entry count, range 0..DEPTH.
- underflow_err  out  1  sticky error flag.

Behaviour:
- Reset (reset=0 at a rising edge):
  - gnt=0, fifo_wr_en=0, fifo_wr_data=0, occupancy=0, underflow_err=0.
  - Internal state: rr_ptr=0, owner=none, burst_cnt=0.
  - Reset mid-operation abandons any burst. A grant already pulsed is not re-counted.
- Per-cycle signals:
  - eligible = req & req_mask.
  - rd_acc = fifo_rd_en & ~fifo_empty.
  - space = (occupancy < DEPTH).
- Arbitration, each cycle when space=1 and eligible≠0:
  - Burst continues: owner valid, eligible[owner]=1, and burst_cnt < MAX_BURST-1 → winner=owner, burst_cnt++.
  - Otherwise, rotate: winner = first set bit of eligible scanning rr_ptr, rr_ptr+1, … mod N. Then owner=winner, burst_cnt=0, rr_ptr=(winner+1) mod N.
- Win, single registered stage. At the next edge:
  - gnt=onehot(winner), fifo_wr_en=1, fifo_wr_data=req_data[winner].
  - Grant latency is 1 cycle from the cycle req is sampled eligible.
- No win (space=0 or eligible=0):
  - gnt=0, fifo_wr_en=0, fifo_wr_data holds its value.
  - owner is cleared if eligible[owner]=0. Rotation resumes from rr_ptr.
- Handshake:
  - Requester i sees gnt[i]=1 for exactly one cycle per accepted word.
  - It must change data, or drop req, in the cycle after gnt.
  - A req still high in the gnt cycle is treated as the next word. This allows back-to-back grants every cycle within a burst.
- Occupancy, updated at each edge: occupancy += win − rd_acc.
  - win and rd_acc in the same cycle → unchanged.
  - rd_acc with occupancy=0 → occupancy stays 0 and underflow_err is set. It clears only on reset.
- Full boundary:
  - At occupancy=DEPTH no grant is issued, even if the FIFO's full flag still reads 0.
  - A read accepted in that cycle makes space=1 the following cycle. It does not take effect in the same cycle; this is deliberately conservative.
- Masking mid-burst: clearing req_mask[owner] ends the burst immediately, and the next winner is chosen by rotation.
- Width rules:
  - occupancy never exceeds DEPTH and never wraps.
  - rr_ptr and owner are log2(N) bits; the rotation wraps from N-1 to 0.

Test Plan:
- Single requester: req=4'b0001, data0=8'hA5 for 1 cycle after reset → gnt=0001 and fifo_wr_en=1 with fifo_wr_data=A5 at cycle+1; occupancy=1.
- Round-robin with bursts: req=1111 held, all masks 1, no reads → grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3 (MAX_BURST=4); then occupancy=16 and grants stop.
- Full-stall release: occupancy=16 with req=0010 held; pulse fifo_rd_en with fifo_empty=0 for 1 cycle → occupancy 15, then one grant to requester 1 the following cycle, occupancy back to 16.
- Simultaneous write and read: occupancy=5, continuous win with rd_acc each cycle for 10 cycles → occupancy stays 5.
- Mask and underflow: req=0011 with owner=0 mid-burst, clear req_mask[0] → next grant goes to requester 1. Separately, occupancy=0 with fifo_rd_en=1 and fifo_empty=0 → underflow_err=1 and occupancy=0.
- Reset mid-burst: reset=0 for 1 cycle during a burst → gnt=0, fifo_wr_en=0, occupancy=0; first grant after reset with req=1110 goes to requester 1.
